laundry_request_scheduler: RTL and testbench
============================================

// Module: laundry_request_scheduler
// PURPOSE
//  Round-robin scheduler for the shared laundry cart/washer. Latches per-floor laundry requests from
//  floors 1..NUM_FLOORS, picks one fairly, then runs one job: fetch from the floor, travel to the laundry
//  room (floor 0), wash, return and deliver. Sits between the floor request buttons and the floor
//  indicator/done logic, and owns its own step/wash timer.
// PARAMETERS
//  NUM_FLOORS  4   requesting floors; request bit i = floor i+1
//  FLOOR_W     3   width of floor numbers; must hold NUM_FLOORS
//  TRAVEL_CYC  10  cycles per one-floor cart step (>=1)
//  WASH_CYC    50  cycles of washing (>=1)
//  CNT_W       6   timer width; must hold max(TRAVEL_CYC,WASH_CYC)-1
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           synchronous, active-low reset
//  start         in   1           level enable; jobs are granted only while high
//  req_laundry   in   NUM_FLOORS  level/pulse request, sampled every cycle
//  pending       out  NUM_FLOORS  latched, not-yet-granted requests
//  busy          out  1           high in every state except IDLE
//  served_floor  out  FLOOR_W     floor of current job; 0 when idle
//  at_floor      out  FLOOR_W     current cart floor
//  wash_active   out  1           high only in WASH
//  wash_done     out  1           1-cycle pulse in DONE (job delivered)
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, pending=0, at_floor=0, served_floor=0, rr_ptr=NUM_FLOORS-1,
//   timer=0, all pulses low. Reset mid-job aborts it; no wash_done is issued.
//  Pending: pending[i] <= pending[i] | req_laundry[i]; the granted bit is cleared on grant. If req and
//   grant hit the same bit in the same cycle, set wins (re-queued). A request for the job's own floor
//   during that job is simply latched.
//  Arbitration: the first pending bit strictly after rr_ptr, wrapping modulo NUM_FLOORS. On grant,
//   rr_ptr := granted index.
//  FSM:
//   IDLE: if start && |pending: grant, served_floor := idx+1, timer := 0, go to PICKUP.
//         Otherwise stay. Grant is registered; a request at edge t is visible in pending at t+1,
//         and PICKUP is entered at t+2.
//   PICKUP / TO_LAUNDRY / DELIVER: travel legs, with target = served_floor / 0 / served_floor.
//         If at_floor==target at entry, move on the next edge (1 cycle).
//         Else: timer counts 0..TRAVEL_CYC-1. At terminal count, at_floor steps +-1 toward the target
//         and the timer resets. Leave the leg on the same edge that at_floor reaches the target.
//         Next states: PICKUP->TO_LAUNDRY, TO_LAUNDRY->WASH, DELIVER->DONE.
//   WASH:  timer counts 0..WASH_CYC-1; at terminal go to DELIVER. wash_active=1.
//   DONE:  wash_done=1 for exactly one cycle, served_floor := 0, go to IDLE. No grant is made in DONE.
//  Dropping start mid-job does not abort the job; it only blocks the next grant.
//  The cart parks where it delivered (at_floor is not reset between jobs).
//  Timer never wraps: it is cleared on every state change.
// STRUCTURE
//  laundry_pkg: state enum (IDLE, PICKUP, TO_LAUNDRY, WASH, DELIVER, DONE), LAUNDRY_FLOOR=0,
//   floor/timer width constants shared with counter/comparator/FSM blocks.
//  Sub-module laundry_rr_arbiter: pending + rr_ptr -> grant_valid, grant_idx
//   (combinational search; pointer held in parent).
//  Travel legs share one leg-engine in the parent (target mux + one timer); no separate counter instance.
// TESTING
//  1 Reset, start=1, req_laundry=4'b0100 one cycle
//    -> PICKUP at t+2, served_floor=3; at_floor 0->1->2->3 every 10 cycles; back to 0; wash_active 50 cycles;
//       back to 3; wash_done 140 cycles after PICKUP entry; pending=0.
//  2 req=4'b1111 at once, start=1
//    -> service order floors 1,2,3,4; four wash_done pulses; rr_ptr ends at 3.
//  3 Cart parked at 2, then req floor 2
//    -> PICKUP lasts 1 cycle; job completes in 1+20+50+20 cycles plus DONE.
//  4 start=0 with pending=4'b0010
//    -> stays IDLE, busy=0; start=1 -> grant floor 2.
//  5 reset=0 for 1 cycle during WASH
//    -> next cycle IDLE, at_floor=0, pending=0, no wash_done.
//  6 req floor 1 held during its own job
//    -> pending[0] re-set; second job for floor 1 follows DONE.

Source files
------------

// File: rtl/laundry_pkg.sv
// Shared types and constants for the laundry request scheduler: FSM states, the laundry-room floor,
// and default floor/timer widths used by the arbiter and the leg engine.
package laundry_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPickup,
    StToLaundry,
    StWash,
    StDeliver,
    StDone
  } state_e;

  localparam int unsigned LAUNDRY_FLOOR = 0;
  localparam int unsigned DEF_FLOOR_W   = 3;
  localparam int unsigned DEF_CNT_W     = 6;

endpackage

// File: rtl/laundry_rr_arbiter.sv
// Combinational round-robin search: first pending bit strictly after the pointer, wrapping.
// The pointer register itself lives in the parent.
module laundry_rr_arbiter #(
  parameter int unsigned NumFloors = 4,
  parameter int unsigned IdxW      = 2
) (
  input  logic [NumFloors-1:0] pending_i,
  input  logic [IdxW-1:0]      rr_ptr_i,
  output logic                 grant_valid_o,
  output logic [IdxW-1:0]      grant_idx_o
);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    // Offset NumFloors wraps back onto the pointer itself, so it is tried last.
    for (int unsigned off = 1; off <= NumFloors; off++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_i) + off) % NumFloors;
      if (!grant_valid_o && pending_i[IdxW'(idx)]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/laundry_request_scheduler.sv
// Round-robin laundry job scheduler: latches floor requests, grants one fairly, then runs a
// fetch / travel / wash / deliver job with one shared step-and-wash timer.
module laundry_request_scheduler
  import laundry_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 4,
  parameter int unsigned FLOOR_W    = DEF_FLOOR_W,
  parameter int unsigned TRAVEL_CYC = 10,
  parameter int unsigned WASH_CYC   = 50,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic [NUM_FLOORS-1:0] req_laundry_i,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  busy_o,
  output logic [FLOOR_W-1:0]    served_floor_o,
  output logic [FLOOR_W-1:0]    at_floor_o,
  output logic                  wash_active_o,
  output logic                  wash_done_o
);

  localparam int unsigned IdxW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

  state_e                state_q;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [IdxW-1:0]       rr_ptr_q;
  logic [FLOOR_W-1:0]    served_floor_q;
  logic [FLOOR_W-1:0]    at_floor_q;
  logic [CNT_W-1:0]      timer_q;

  logic                  grant_valid;
  logic [IdxW-1:0]       grant_idx;
  logic                  grant_fire;
  logic [NUM_FLOORS-1:0] grant_mask;

  logic [FLOOR_W-1:0]    leg_target;
  logic [FLOOR_W-1:0]    step_floor;
  state_e                leg_next;
  logic                  travel_tc;
  logic                  wash_tc;

  laundry_rr_arbiter #(
    .NumFloors(NUM_FLOORS),
    .IdxW     (IdxW)
  ) u_arbiter (
    .pending_i    (pending_q),
    .rr_ptr_i     (rr_ptr_q),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

  assign grant_fire = (state_q == StIdle) && start_i && grant_valid;
  assign grant_mask = {{(NUM_FLOORS-1){1'b0}}, grant_fire} << grant_idx;
  // A request landing on the bit being granted re-queues it.
  assign pending_d  = (pending_q & ~grant_mask) | req_laundry_i;

  always_comb begin
    leg_target = served_floor_q;
    leg_next   = StIdle;
    unique case (state_q)
      StPickup:    leg_next = StToLaundry;
      StToLaundry: begin
        leg_target = FLOOR_W'(LAUNDRY_FLOOR);
        leg_next   = StWash;
      end
      StDeliver:   leg_next = StDone;
      default:     leg_next = StIdle;
    endcase
  end

  assign step_floor = (at_floor_q < leg_target) ? at_floor_q + FLOOR_W'(1)
                                                : at_floor_q - FLOOR_W'(1);
  assign travel_tc  = (timer_q == CNT_W'(TRAVEL_CYC - 1));
  assign wash_tc    = (timer_q == CNT_W'(WASH_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      rr_ptr_q       <= IdxW'(NUM_FLOORS - 1);
      served_floor_q <= '0;
      at_floor_q     <= '0;
      timer_q        <= '0;
    end else begin
      pending_q <= pending_d;
      unique case (state_q)
        StIdle: begin
          if (grant_fire) begin
            state_q        <= StPickup;
            served_floor_q <= FLOOR_W'(grant_idx) + FLOOR_W'(1);
            rr_ptr_q       <= grant_idx;
            timer_q        <= '0;
          end
        end
        StPickup, StToLaundry, StDeliver: begin
          if (at_floor_q == leg_target) begin
            state_q <= leg_next;
            timer_q <= '0;
          end else if (travel_tc) begin
            at_floor_q <= step_floor;
            timer_q    <= '0;
            if (step_floor == leg_target) state_q <= leg_next;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        StWash: begin
          if (wash_tc) begin
            state_q <= StDeliver;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        StDone: begin
          state_q        <= StIdle;
          served_floor_q <= '0;
          timer_q        <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pending_o      = pending_q;
  assign busy_o         = (state_q != StIdle);
  assign served_floor_o = served_floor_q;
  assign at_floor_o     = at_floor_q;
  assign wash_active_o  = (state_q == StWash);
  assign wash_done_o    = (state_q == StDone);

endmodule

// File: tb/tb_laundry_request_scheduler.sv
// Directed bench for laundry_request_scheduler: expected served floors are queued when requests
// are driven and popped when wash_done is seen.
module tb_laundry_request_scheduler;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       start_i;
  logic [3:0] req_laundry_i;
  logic [3:0] pending_o;
  logic       busy_o;
  logic [2:0] served_floor_o;
  logic [2:0] at_floor_o;
  logic       wash_active_o;
  logic       wash_done_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int t0 = 0;
  int d0 = 0;
  int exp_q[$];

  laundry_request_scheduler dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .start_i       (start_i),
    .req_laundry_i (req_laundry_i),
    .pending_o     (pending_o),
    .busy_o        (busy_o),
    .served_floor_o(served_floor_o),
    .at_floor_o    (at_floor_o),
    .wash_active_o (wash_active_o),
    .wash_done_o   (wash_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) if (wash_done_o) done_cnt <= done_cnt + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for wash_done, pops the expected floor and checks it; exp_lat < 0 skips the latency check.
  task automatic wait_done(input int bound, input int exp_lat);
    int n;
    int exp_floor;
    n = 0;
    while (!wash_done_o && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    if (!wash_done_o) begin
      chk("done_timeout", 0, 1);
    end else begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_floor = exp_q.pop_front();
        chk("served_floor", 32'(served_floor_o), exp_floor);
        chk("cart_at_delivery", 32'(at_floor_o), exp_floor);
      end
      if (exp_lat >= 0) chk("job_latency", cyc - t0, exp_lat);
      step(1);
      chk("done_one_cycle", 32'(wash_done_o), 0);
    end
  endtask

  task automatic wait_wash(input int bound);
    int n;
    n = 0;
    while (!wash_active_o && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    chk("wash_reached", 32'(wash_active_o), 1);
  endtask

  initial begin
    reset_ni      = 1'b0;
    start_i       = 1'b0;
    req_laundry_i = 4'b0000;
    step(3);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_pending", 32'(pending_o), 0);
    chk("rst_at_floor", 32'(at_floor_o), 0);
    chk("rst_served", 32'(served_floor_o), 0);
    chk("rst_wash_active", 32'(wash_active_o), 0);
    chk("rst_wash_done", 32'(wash_done_o), 0);

    // Single job to floor 3 with full timing profile.
    reset_ni      = 1'b1;
    start_i       = 1'b1;
    req_laundry_i = 4'b0100;
    exp_q.push_back(3);
    step(1);
    req_laundry_i = 4'b0000;
    chk("t1_pending_latched", 32'(pending_o), 4'b0100);
    chk("t1_busy_before_grant", 32'(busy_o), 0);
    step(1);
    t0 = cyc;
    chk("t1_busy", 32'(busy_o), 1);
    chk("t1_served", 32'(served_floor_o), 3);
    chk("t1_pending_cleared", 32'(pending_o), 0);
    step(9);
    chk("t1_floor_9", 32'(at_floor_o), 0);
    step(1);
    chk("t1_floor_10", 32'(at_floor_o), 1);
    step(20);
    chk("t1_floor_30", 32'(at_floor_o), 3);
    step(30);
    chk("t1_floor_60", 32'(at_floor_o), 0);
    chk("t1_wash_start", 32'(wash_active_o), 1);
    step(49);
    chk("t1_wash_last", 32'(wash_active_o), 1);
    step(1);
    chk("t1_wash_end", 32'(wash_active_o), 0);
    wait_done(200, 140);
    chk("t1_idle_busy", 32'(busy_o), 0);
    chk("t1_idle_served", 32'(served_floor_o), 0);
    chk("t1_idle_pending", 32'(pending_o), 0);

    // Reset, then all floors at once: round-robin from pointer 3 serves 1,2,3,4.
    reset_ni = 1'b0;
    step(1);
    reset_ni = 1'b1;
    chk("t2_reset_floor", 32'(at_floor_o), 0);
    req_laundry_i = 4'b1111;
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(4);
    step(1);
    req_laundry_i = 4'b0000;
    wait_done(300, -1);
    wait_done(300, -1);
    wait_done(300, -1);
    wait_done(300, -1);

    // start low holds the request pending; raising it grants floor 2.
    start_i       = 1'b0;
    req_laundry_i = 4'b0010;
    step(1);
    req_laundry_i = 4'b0000;
    step(4);
    chk("t4_idle_busy", 32'(busy_o), 0);
    chk("t4_pending_held", 32'(pending_o), 4'b0010);
    start_i = 1'b1;
    exp_q.push_back(2);
    step(1);
    chk("t4_busy", 32'(busy_o), 1);
    chk("t4_served", 32'(served_floor_o), 2);
    wait_done(300, -1);

    // Cart parked at 2, request floor 2: pickup leg takes one cycle.
    req_laundry_i = 4'b0010;
    exp_q.push_back(2);
    step(1);
    req_laundry_i = 4'b0000;
    step(1);
    t0 = cyc;
    chk("t3_served", 32'(served_floor_o), 2);
    chk("t3_floor", 32'(at_floor_o), 2);
    wait_done(200, 91);

    // Floor 1 held during its own job re-queues it.
    req_laundry_i = 4'b0001;
    exp_q.push_back(1);
    exp_q.push_back(1);
    step(2);
    chk("t6_served", 32'(served_floor_o), 1);
    chk("t6_requeued", 32'(pending_o), 4'b0001);
    step(5);
    req_laundry_i = 4'b0000;
    wait_done(300, -1);
    wait_done(300, -1);

    // Reset mid-wash aborts the job with no wash_done.
    req_laundry_i = 4'b0100;
    step(1);
    req_laundry_i = 4'b0000;
    wait_wash(300);
    req_laundry_i = 4'b1000;
    step(1);
    req_laundry_i = 4'b0000;
    chk("t5_pending_in_wash", 32'(pending_o), 4'b1000);
    d0 = done_cnt;
    reset_ni = 1'b0;
    step(1);
    reset_ni = 1'b1;
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_floor", 32'(at_floor_o), 0);
    chk("t5_pending", 32'(pending_o), 0);
    chk("t5_served", 32'(served_floor_o), 0);
    step(200);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_still_idle", 32'(busy_o), 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
